// File: rtl/debug_ocimem_sequencer.sv
// Debug RAM access sequencer: turns JTAG debug-slave strobes into address-load,
// read-next and write-next cycles on a fixed-latency debug RAM.
module debug_ocimem_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic [31:0] ram_rdata,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  output logic        ram_re,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_CAPT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  addr, addr_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] mon_nxt;
  logic        err_nxt;
  logic        any_strobe;

  // Only the address field, read flag and write-data field carry meaning.
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

  // Word address wraps silently at the top of the 256-word window.
  function automatic logic [7:0] addr_inc(input logic [7:0] a);
    return a + 8'd1;
  endfunction

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign ram_addr   = addr;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    wdata_nxt = ram_wdata;
    mon_nxt   = MonDReg;
    err_nxt   = monitor_error;
    case (state)
      IDLE: begin
        // Priority a > b > no_action; losers in the same cycle are errors.
        if (take_action_ocimem_a) begin
          addr_nxt  = jdo[25:18];
          err_nxt   = take_action_ocimem_b | take_no_action_ocimem_a;
          state_nxt = jdo[17] ? RD_ISSUE : IDLE;
        end else if (take_action_ocimem_b) begin
          wdata_nxt = jdo[34:3];
          state_nxt = WR;
          if (take_no_action_ocimem_a) err_nxt = 1'b1;
        end else if (take_no_action_ocimem_a) begin
          state_nxt = RD_ISSUE;
        end
      end
      WR: begin
        addr_nxt  = addr_inc(addr);
        state_nxt = IDLE;
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = RD_CAPT;
      RD_CAPT: begin
        // RAM data arrives two cycles after the ram_re cycle.
        mon_nxt   = ram_rdata;
        addr_nxt  = addr_inc(addr);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && any_strobe) err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      addr          <= 8'h00;
      MonDReg       <= 32'h0;
      ram_wdata     <= 32'h0;
      ram_we        <= 1'b0;
      ram_re        <= 1'b0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr          <= addr_nxt;
      MonDReg       <= mon_nxt;
      ram_wdata     <= wdata_nxt;
      ram_we        <= (state_nxt == WR);
      ram_re        <= (state_nxt == RD_ISSUE);
      monitor_ready <= (state_nxt == IDLE);
      monitor_error <= err_nxt;
    end
  end

endmodule

// File: tb/tb_debug_ocimem_sequencer.sv
// Directed bench for debug_ocimem_sequencer: cycle-by-cycle vector table plus
// hand-written reset-abort sequence, against a fixed-latency RAM model.
module tb_debug_ocimem_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0] ram_rdata;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, MonDReg;
  logic        ram_we, ram_re, monitor_ready, monitor_error;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debug_ocimem_sequencer dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .ram_rdata              (ram_rdata),
    .ram_addr               (ram_addr),
    .ram_wdata              (ram_wdata),
    .ram_we                 (ram_we),
    .ram_re                 (ram_re),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  // RAM model: contents fixed, data valid two cycles after the ram_re cycle.
  function automatic logic [31:0] rom(input logic [7:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'hFF:   return 32'hCAFEF00D;
      8'h20:   return 32'h0BADF00D;
      8'h50:   return 32'hA5A5A5A5;
      8'h60:   return 32'h11111111;
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] rd_p1 = 32'h0;
  logic [31:0] rd_p2 = 32'h0;
  logic        force_en = 1'b0;
  logic [31:0] force_val = 32'h0;
  always @(posedge clk) begin
    rd_p1 <= ram_re ? rom(ram_addr) : 32'h0;
    rd_p2 <= rd_p1;
  end
  assign ram_rdata = force_en ? force_val : rd_p2;

  function automatic logic [37:0] ja(input logic [7:0] a, input logic rd);
    return {12'hABC, a, rd, 17'h15555};
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] w);
    return {3'b101, w, 3'b011};
  endfunction

  typedef struct {
    logic        a, na, b;
    logic [37:0] jdo;
    logic [7:0]  addr;
    logic        re, we, rdy, err;
    logic [31:0] mon, wd;
  } vec_t;

  function automatic vec_t mv(input logic a, na, b, input logic [37:0] j,
                              input logic [7:0] ad, input logic re, we, rdy, err,
                              input logic [31:0] mon, wd);
    vec_t v;
    v.a = a; v.na = na; v.b = b; v.jdo = j; v.addr = ad;
    v.re = re; v.we = we; v.rdy = rdy; v.err = err; v.mon = mon; v.wd = wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " addr"},  {24'h0, ram_addr}, 32'h0);
    check({tag, " mon"},   MonDReg, 32'h0);
    check({tag, " wdata"}, ram_wdata, 32'h0);
    check({tag, " we"},    {31'h0, ram_we}, 32'h0);
    check({tag, " re"},    {31'h0, ram_re}, 32'h0);
    check({tag, " ready"}, {31'h0, monitor_ready}, 32'h1);
    check({tag, " error"}, {31'h0, monitor_error}, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = 38'h0;
  endtask

  vec_t vecs[20];

  initial begin
    vecs[0]  = mv(1,0,0, ja(8'h10,1'b1),   8'h10, 1,0,0,0, 32'h0,        32'h0);
    vecs[1]  = mv(0,0,0, 38'h0,            8'h10, 0,0,0,0, 32'h0,        32'h0);
    vecs[2]  = mv(0,0,0, 38'h0,            8'h10, 0,0,0,0, 32'h0,        32'h0);
    vecs[3]  = mv(0,0,0, 38'h0,            8'h11, 0,0,1,0, 32'hDEADBEEF, 32'h0);
    vecs[4]  = mv(0,0,1, jb(32'h12345678), 8'h11, 0,1,0,0, 32'hDEADBEEF, 32'h12345678);
    vecs[5]  = mv(0,0,0, 38'h0,            8'h12, 0,0,1,0, 32'hDEADBEEF, 32'h12345678);
    vecs[6]  = mv(1,0,0, ja(8'hFF,1'b0),   8'hFF, 0,0,1,0, 32'hDEADBEEF, 32'h12345678);
    vecs[7]  = mv(0,1,0, ja(8'h33,1'b1),   8'hFF, 1,0,0,0, 32'hDEADBEEF, 32'h12345678);
    vecs[8]  = mv(0,0,0, 38'h0,            8'hFF, 0,0,0,0, 32'hDEADBEEF, 32'h12345678);
    vecs[9]  = mv(0,0,0, 38'h0,            8'hFF, 0,0,0,0, 32'hDEADBEEF, 32'h12345678);
    vecs[10] = mv(0,0,0, 38'h0,            8'h00, 0,0,1,0, 32'hCAFEF00D, 32'h12345678);
    vecs[11] = mv(1,0,0, ja(8'h20,1'b1),   8'h20, 1,0,0,0, 32'hCAFEF00D, 32'h12345678);
    vecs[12] = mv(0,0,0, 38'h0,            8'h20, 0,0,0,0, 32'hCAFEF00D, 32'h12345678);
    vecs[13] = mv(0,0,1, jb(32'h99999999), 8'h20, 0,0,0,1, 32'hCAFEF00D, 32'h12345678);
    vecs[14] = mv(0,0,0, 38'h0,            8'h21, 0,0,1,1, 32'h0BADF00D, 32'h12345678);
    vecs[15] = mv(1,0,0, ja(8'h30,1'b0),   8'h30, 0,0,1,0, 32'h0BADF00D, 32'h12345678);
    vecs[16] = mv(1,0,1, ja(8'h40,1'b0),   8'h40, 0,0,1,1, 32'h0BADF00D, 32'h12345678);
    vecs[17] = mv(0,0,0, 38'h0,            8'h40, 0,0,1,1, 32'h0BADF00D, 32'h12345678);
    vecs[18] = mv(0,1,1, jb(32'h55AA55AA), 8'h40, 0,1,0,1, 32'h0BADF00D, 32'h55AA55AA);
    vecs[19] = mv(0,0,0, 38'h0,            8'h41, 0,0,1,1, 32'h0BADF00D, 32'h55AA55AA);

    reset_n = 1'b0;
    clr_strobes();
    repeat (3) tick();
    check_reset_vals("initial reset");

    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      take_action_ocimem_a    = vecs[i].a;
      take_no_action_ocimem_a = vecs[i].na;
      take_action_ocimem_b    = vecs[i].b;
      jdo                     = vecs[i].jdo;
      tick();
      clr_strobes();
      check($sformatf("v%0d addr", i),  {24'h0, ram_addr}, {24'h0, vecs[i].addr});
      check($sformatf("v%0d re", i),    {31'h0, ram_re}, {31'h0, vecs[i].re});
      check($sformatf("v%0d we", i),    {31'h0, ram_we}, {31'h0, vecs[i].we});
      check($sformatf("v%0d ready", i), {31'h0, monitor_ready}, {31'h0, vecs[i].rdy});
      check($sformatf("v%0d error", i), {31'h0, monitor_error}, {31'h0, vecs[i].err});
      check($sformatf("v%0d mon", i),   MonDReg, vecs[i].mon);
      check($sformatf("v%0d wdata", i), ram_wdata, vecs[i].wd);
      check($sformatf("v%0d we&re", i), {31'h0, ram_we & ram_re}, 32'h0);
    end

    // Preload MonDReg with 0xA5A5A5A5 by a normal read at 0x50.
    take_action_ocimem_a = 1'b1;
    jdo = ja(8'h50, 1'b1);
    tick();
    clr_strobes();
    repeat (3) tick();
    check("preload mon", MonDReg, 32'hA5A5A5A5);
    check("preload addr", {24'h0, ram_addr}, 32'h51);

    // Start a read at 0x60 and reset while in RD_WAIT, with a coincident strobe.
    take_action_ocimem_a = 1'b1;
    jdo = ja(8'h60, 1'b1);
    tick();
    clr_strobes();
    check("abort issue re", {31'h0, ram_re}, 32'h1);
    tick();
    check("abort wait ready", {31'h0, monitor_ready}, 32'h0);
    check("abort wait mon", MonDReg, 32'hA5A5A5A5);
    reset_n = 1'b0;
    take_action_ocimem_b = 1'b1;
    jdo = jb(32'hFFFFFFFF);
    tick();
    clr_strobes();
    reset_n = 1'b1;
    check_reset_vals("reset in RD_WAIT");

    // Late RAM data from the aborted read, then a forced value, must be ignored.
    for (int k = 0; k < 4; k++) begin
      if (k >= 1) begin
        force_en  = 1'b1;
        force_val = 32'h77777777;
      end
      tick();
      check_reset_vals($sformatf("post-abort cycle %0d", k));
    end
    force_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_ocimem_sequencer.md
DEBUG_OCIMEM_SEQUENCER -- requirements
Module: debug_ocimem_sequencer

Interface
REQ-001 SHALL provide: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide: reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL provide: jdo  input  38  debug command payload from the JTAG debug slave, clk domain, valid only in strobe cycles.
REQ-004 SHALL provide: take_action_ocimem_a  input  1  one-cycle strobe, address-load command.
REQ-005 SHALL provide: take_no_action_ocimem_a  input  1  one-cycle strobe, read-next command.
REQ-006 SHALL provide: take_action_ocimem_b  input  1  one-cycle strobe, write-next command.
REQ-007 SHALL provide: ram_rdata  input  32  debug RAM read data, fixed latency.
REQ-008 SHALL provide: ram_addr  output  8  debug RAM word address, equal to the internal address register.
REQ-009 SHALL provide: ram_wdata  output  32  debug RAM write data, registered.
REQ-010 SHALL provide: ram_we  output  1  write enable, one-cycle pulse.
REQ-011 SHALL provide: ram_re  output  1  read enable, one-cycle pulse.
REQ-012 SHALL provide: MonDReg  output  32  last read data, returned to the debug slave for shift-out.
REQ-013 SHALL provide: monitor_ready  output  1  high when idle or when the last command is complete.
REQ-014 SHALL provide: monitor_error  output  1  sticky flag for a dropped command.

Function
REQ-015 SHALL implement states IDLE, WR, RD_ISSUE, RD_WAIT, RD_CAPT, with all outputs registered.
REQ-016 SHALL act in IDLE on strobe priority: ocimem_a, then ocimem_b, then no_action_ocimem_a; lower-priority strobes in the same cycle SHALL be dropped and SHALL set monitor_error.
REQ-017 SHALL handle ocimem_a at edge E0: addr <= jdo[25:18]; monitor_error <= 0; if jdo[17]=1, enter RD_ISSUE, else stay IDLE with monitor_ready=1.
REQ-018 SHALL handle no_action_ocimem_a at E0 by entering RD_ISSUE with addr unchanged.
REQ-019 SHALL run the read sequence as follows: after E0, ram_re=1 and monitor_ready=0 (RD_ISSUE); E1 to RD_WAIT with ram_re=0; E2 to RD_CAPT; E3: MonDReg <= ram_rdata, addr <= addr+1, monitor_ready=1, IDLE.
REQ-020 SHALL use the read timing contract that ram_rdata is valid in the second cycle after the cycle in which ram_re is high.
REQ-021 SHALL handle ocimem_b at E0: ram_wdata <= jdo[34:3]; enter WR with ram_we=1 and monitor_ready=0 for exactly one cycle; at E1 addr <= addr+1, monitor_ready=1, IDLE.
REQ-022 SHALL increment the address modulo 256 (0xFF+1 = 0x00), with no error flagged.
REQ-023 SHALL drop any strobe arriving outside IDLE, leaving state, addr and data unaffected, and SHALL set monitor_error=1.
REQ-024 SHALL hold monitor_error until the next accepted ocimem_a or reset.
REQ-025 SHALL never assert ram_we and ram_re in the same cycle.
REQ-026 SHALL leave MonDReg unchanged except in RD_CAPT.
REQ-027 SHALL ignore jdo bits other than those named in REQ-017 and REQ-021.

Reset
REQ-028 SHALL, when reset_n=0 at a rising edge, force: state IDLE, addr=0x00, MonDReg=0, ram_wdata=0, ram_we=0, ram_re=0, monitor_ready=1, monitor_error=0.
REQ-029 SHALL, on reset mid-read or mid-write, abort the operation: no MonDReg update, no address increment, and any late ram_rdata ignored.
REQ-030 SHALL ignore strobes coincident with reset_n=0.

Verification
REQ-031 SHALL cover: ocimem_a with jdo[25:18]=0x10, jdo[17]=1, RAM[0x10]=0xDEADBEEF -> ram_re high 1 cycle at addr 0x10; MonDReg=0xDEADBEEF 4 edges after strobe; addr=0x11; ready=1.
REQ-032 SHALL cover: ocimem_b with jdo[34:3]=0x12345678 at addr 0x11 -> ram_we 1 cycle with wdata 0x12345678, addr 0x11; then addr=0x12.
REQ-033 SHALL cover: load addr 0xFF without read, then no_action_ocimem_a -> read at 0xFF; addr wraps to 0x00; monitor_error=0.
REQ-034 SHALL cover: ocimem_b strobe during RD_WAIT -> no ram_we, read completes normally, monitor_error=1; next ocimem_a clears it to 0.
REQ-035 SHALL cover: ocimem_a and ocimem_b in the same cycle -> load only, no write, monitor_error=1.
REQ-036 SHALL cover: reset_n=0 in RD_WAIT with MonDReg=0xA5A5A5A5 -> next cycle all outputs at REQ-028 values; ram_rdata driven later has no effect on MonDReg.
